// File: rtl/clb_cfg_loader.sv
// Serial CLB configuration loader: hunts SYNC, reads an ADDR_W-bit frame count,
// then deserialises one 37-bit word per CLB and writes it with a one-cycle strobe.
// Latency: CFG_WE pulses the cycle after the last frame bit is sampled; DVALID low stalls all state.
// Optional build macro: CLB_CFG_PARITY_EN (adds an even-parity bit per frame and the ERR state).
module clb_cfg_loader #(
    parameter int         ADDR_W = 8,
    parameter logic [7:0] SYNC   = 8'hB2
) (
    input  logic              K,
    input  logic              RST,
    input  logic              DIN,
    input  logic              DVALID,
    output logic              CFG_WE,
    output logic [ADDR_W-1:0] CFG_ADDR,
    output logic [36:0]       CFG_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

`ifdef CLB_CFG_PARITY_EN
    // 37 data bits followed by one even-parity bit; the shifter keeps all 37 data bits
    // so the parity bit can be checked against the complete word.
    localparam int FRAME_BITS = 38;
    localparam int SH_W       = 37;
`else
    // The 37th bit is merged straight into the strobe word, so only 36 bits need holding.
    localparam int FRAME_BITS = 37;
    localparam int SH_W       = 36;
`endif

    // Shared bit counter for the length field and the frame body.
    localparam int CNT_W = 9;

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_FRAME,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state, state_n;
    logic [7:0]          hist, hist_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [ADDR_W-1:0]   n_reg, n_n;
    logic [ADDR_W-1:0]   idx, idx_n;
    logic [SH_W-1:0]     sh, sh_n;
    logic                cfg_we, cfg_we_n;
    logic [ADDR_W-1:0]   cfg_addr, cfg_addr_n;
    logic [36:0]         cfg_data, cfg_data_n;

    logic [7:0]          hist_shift;
    logic [ADDR_W-1:0]   len_shift;
    logic [ADDR_W-1:0]   idx_inc;
    logic                fire;
    logic [36:0]         fire_word;

    assign hist_shift = {hist[6:0], DIN};
    assign len_shift  = ADDR_W'({n_reg, DIN});
    assign idx_inc    = idx + 1'b1;

    // Next-state and datapath: nothing moves unless DVALID is high.
    always_comb begin
        state_n    = state;
        hist_n     = hist;
        cnt_n      = cnt;
        n_n        = n_reg;
        idx_n      = idx;
        sh_n       = sh;
        cfg_we_n   = 1'b0;
        cfg_addr_n = cfg_addr;
        cfg_data_n = cfg_data;
        fire       = 1'b0;
        fire_word  = 37'd0;

        if (DVALID) begin
            case (state)
                S_HUNT: begin
                    hist_n = hist_shift;
                    if (hist_shift == SYNC) begin
                        state_n = S_LEN;
                        cnt_n   = '0;
                    end
                end
                S_LEN: begin
                    n_n = len_shift;
                    if (cnt == CNT_W'(ADDR_W - 1)) begin
                        cnt_n = '0;
                        idx_n = '0;
                        if (len_shift == '0) begin
                            state_n = S_DONE;
                        end else begin
                            state_n = S_FRAME;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                S_FRAME: begin
                    if (cnt == CNT_W'(FRAME_BITS - 1)) begin
                        cnt_n = '0;
`ifdef CLB_CFG_PARITY_EN
                        // Final bit is the parity bit; a mismatch drops the frame for good.
                        if (DIN != ^sh) begin
                            state_n = S_ERR;
                        end else begin
                            fire      = 1'b1;
                            fire_word = sh;
                        end
`else
                        fire      = 1'b1;
                        fire_word = {sh, DIN};
`endif
                    end else begin
                        sh_n  = SH_W'({sh, DIN});
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    // DONE and ERR ignore the stream until reset.
                end
            endcase
        end

        // A completed frame is registered and strobed; the last index ends the load.
        if (fire) begin
            cfg_we_n   = 1'b1;
            cfg_addr_n = idx;
            cfg_data_n = fire_word;
            idx_n      = idx_inc;
            if (idx_inc == n_reg) begin
                state_n = S_DONE;
            end
        end
    end

    // State and datapath registers; reset wins over everything, including a pending strobe.
    always_ff @(posedge K) begin
        if (RST) begin
            state    <= S_HUNT;
            hist     <= 8'd0;
            cnt      <= '0;
            n_reg    <= '0;
            idx      <= '0;
            sh       <= '0;
            cfg_we   <= 1'b0;
            cfg_addr <= '0;
            cfg_data <= 37'd0;
        end else begin
            state    <= state_n;
            hist     <= hist_n;
            cnt      <= cnt_n;
            n_reg    <= n_n;
            idx      <= idx_n;
            sh       <= sh_n;
            cfg_we   <= cfg_we_n;
            cfg_addr <= cfg_addr_n;
            cfg_data <= cfg_data_n;
        end
    end

    assign CFG_WE   = cfg_we;
    assign CFG_ADDR = cfg_addr;
    assign CFG_DATA = cfg_data;
    assign BUSY     = (state == S_LEN) || (state == S_FRAME);
    assign DONE     = (state == S_DONE);
`ifdef CLB_CFG_PARITY_EN
    assign ERR      = (state == S_ERR);
`else
    assign ERR      = 1'b0;
`endif

endmodule
